// File: rtl/br_pkg.sv
// br_pkg: branch condition codes and resolve-unit FSM state
package br_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic {IDLE, REDIRECT} br_state_t;
endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: branch outcome from SUB flags; reserved codes are not taken and flagged illegal
module br_cond_eval
  import br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       taken,
  output logic       illegal
);
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = z;
      F3_BNE:  taken = ~z;
      F3_BLT:  taken = n ^ v;
      F3_BGE:  taken = ~(n ^ v);
      F3_BLTU: taken = ~c;
      F3_BGEU: taken = c;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/br_resolve_unit.sv
// br_resolve_unit: M-stage branch resolution, held fetch redirect, predictor update and statistics
module br_resolve_unit
  import br_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_valid,
  input  logic             m_is_branch,
  input  logic             m_is_jump,
  input  logic [2:0]       m_funct3,
  input  logic             m_flag_n,
  input  logic             m_flag_z,
  input  logic             m_flag_c,
  input  logic             m_flag_v,
  input  logic [XLEN-1:0]  m_pc,
  input  logic [XLEN-1:0]  m_target,
  input  logic             m_pred_taken,
  input  logic [XLEN-1:0]  m_pred_target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_young,
  output logic             bht_upd_valid,
  output logic [XLEN-1:0]  bht_upd_pc,
  output logic             bht_upd_taken,
  output logic             illegal_cond,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);
  br_state_t        state_q, state_d;
  logic             cond_taken, cond_illegal, resolve, is_br, taken, mispredict;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d, bht_pc_q, bht_pc_d;
  logic             bht_valid_q, bht_valid_d, bht_taken_q, bht_taken_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  br_cond_eval u_cond (
    .funct3 (m_funct3),
    .n      (m_flag_n),
    .z      (m_flag_z),
    .c      (m_flag_c),
    .v      (m_flag_v),
    .taken  (cond_taken),
    .illegal(cond_illegal)
  );

  // a jump that also carries the branch bit is treated purely as a jump
  always_comb begin
    resolve       = m_valid & (m_is_branch | m_is_jump) & (state_q == IDLE);
    is_br         = m_is_branch & ~m_is_jump;
    taken         = m_is_jump | cond_taken;
    mispredict    = resolve & ((taken != m_pred_taken) | (taken & (m_target != m_pred_target)));
    state_d       = (state_q == IDLE) ? (mispredict ? REDIRECT : IDLE) : (redirect_ready ? IDLE : REDIRECT);
    redirect_pc_d = mispredict ? (taken ? m_target : m_pc + XLEN'(4)) : redirect_pc_q;
    bht_valid_d   = resolve & is_br;
    bht_pc_d      = bht_valid_d ? m_pc : bht_pc_q;
    bht_taken_d   = bht_valid_d & cond_taken;
    illegal_d     = bht_valid_d & cond_illegal;
    br_cnt_d      = (resolve & ~&br_cnt_q) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    mp_cnt_d      = (mispredict & ~&mp_cnt_q) ? mp_cnt_q + CNT_W'(1) : mp_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      bht_valid_q   <= 1'b0;
      bht_pc_q      <= '0;
      bht_taken_q   <= 1'b0;
      illegal_q     <= 1'b0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      bht_valid_q   <= bht_valid_d;
      bht_pc_q      <= bht_pc_d;
      bht_taken_q   <= bht_taken_d;
      illegal_q     <= illegal_d;
      br_cnt_q      <= br_cnt_d;
      mp_cnt_q      <= mp_cnt_d;
    end
  end

  assign redirect_valid   = (state_q == REDIRECT);
  assign redirect_pc      = redirect_pc_q;
  assign flush_young      = mispredict | redirect_valid;
  assign bht_upd_valid    = bht_valid_q;
  assign bht_upd_pc       = bht_pc_q;
  assign bht_upd_taken    = bht_taken_q;
  assign illegal_cond     = illegal_q;
  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;
endmodule
